mdu_hazard_ctrl: RTL and testbench
==================================

Name: mdu_hazard_ctrl

Overview:
Sequencing and stall controller for the multi-cycle multiply/divide unit (MDU) in the 5-stage MIPS pipeline.
- Launches MULT/MULTU/DIV/DIVU when they reach EX.
- Counts MDU latency and pulses the HI/LO write enable on completion.
- Stalls the ID stage while any HI/LO consumer or a second MDU op would collide with an op in flight.
- Sits beside the EX/MEM forwarding units and feeds the same pipeline-stall network.

Parameters:
MULT_LAT, 5, cycles from MDU_start to HiLo_we for MULT/MULTU (legal range 2..15)
DIV_LAT, 10, cycles from MDU_start to HiLo_we for DIV/DIVU (legal range 2..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
EX_isMDU  input  1  EX instruction is MULT/MULTU/DIV/DIVU
EX_isDiv  input  1  with EX_isMDU: 1 = DIV/DIVU, 0 = MULT/MULTU
EX_isSigned  input  1  with EX_isMDU: signed variant
EX_flush  input  1  EX instruction is being squashed this cycle
MDU_abort  input  1  exception commit; kill any op in flight
ID_isR_HiLo  input  1  ID instruction is MFHI/MFLO
ID_isW_HiLo  input  1  ID instruction is MTHI/MTLO
ID_isMDU  input  1  ID instruction is MULT/MULTU/DIV/DIVU
MDU_start  output  1  one-cycle launch pulse to MDU datapath
MDU_op  output  2  {isDiv, isSigned}, valid while MDU_start=1
HiLo_we  output  1  one-cycle HI/LO result write enable
MDU_busy  output  1  op in flight
ID_stall_o  output  1  freeze PC and IF/ID, bubble ID/EX
stall_cnt  output  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0. MDU_start, HiLo_we, MDU_busy and stall_cnt are 0. ID_stall_o=0.
- States: IDLE, BUSY, DONE. State and counter are registered. MDU_busy is registered: 1 in BUSY, 0 otherwise.
- go = EX_isMDU && !EX_flush && !MDU_abort && state!=BUSY. Issue is allowed in IDLE and in DONE (back-to-back ops).
- MDU_start = go. This is combinational and valid in the same cycle as the EX instruction.
- MDU_op = {EX_isDiv, EX_isSigned} when go, else 2'b00.
- On go: next state=BUSY; counter loads (EX_isDiv ? DIV_LAT : MULT_LAT) - 1.
- In BUSY:
  - counter decrements each cycle.
  - When counter==1, next state=DONE.
- In DONE:
  - HiLo_we=1 for exactly one cycle, exactly LAT cycles after the MDU_start cycle.
  - Next state=IDLE, or BUSY if go.
- Latency: MDU_start at cycle T gives HiLo_we at cycle T+MULT_LAT or T+DIV_LAT.
- MDU_abort:
  - In BUSY: next state=IDLE, counter=0, no HiLo_we.
  - Asserted during DONE: HiLo_we is suppressed that cycle.
  - Has priority over go.
- EX_flush in the same cycle as EX_isMDU: no launch, state unchanged.
- ID_stall_o = (ID_isR_HiLo || ID_isW_HiLo || ID_isMDU) && (state==BUSY || go). This is combinational.
  - No stall in DONE, because HiLo is written at the end of DONE. An MFHI in ID during DONE reads the new value in EX via the write-first HI/LO register.
- Stall release: ID_stall_o drops in the cycle state==DONE. The stalled instruction advances at the end of that cycle.
- EX_isMDU while in BUSY is impossible: the ID stall prevents it. If it occurs, it is ignored (go=0, no relaunch).
- Counter width is 4 bits. Parameter values outside 2..15 are illegal. The implementation flags them with a simulation-time $error.

Optional Feature:
Macro MDU_STALL_CNT_EN.
- Defined: stall_cnt is a 32-bit register, reset to 0. It increments on every cycle where ID_stall_o=1, wraps 0xFFFFFFFF→0, and is not cleared by MDU_abort.
- Undefined: stall_cnt is tied to 32'h0 and no counter logic is instantiated. The port list is identical in both builds.

Test Plan:
- Reset mid-BUSY: MULT issued, rst_n low at cycle T+2 → MDU_busy, HiLo_we and stall_cnt=0 immediately (asynchronous); no HiLo_we at T+5 after release.
- MULT at T, MFHI in ID at T+1 → ID_stall_o=1 for T+1..T+4, 0 at T+5; HiLo_we=1 only at T+5; MDU_start=1 only at T, MDU_op=2'b01.
- DIVU at T, DIV in ID at T+1 → stall through T+9; second MDU_start at T+10 with HiLo_we=1 at T+10; second HiLo_we at T+20, MDU_op=2'b10.
- MULT with EX_flush=1 → MDU_start=0, state stays IDLE; DIV at T, MDU_abort at T+4 → MDU_busy=0 at T+5, no HiLo_we at T+10.
- MDU_STALL_CNT_EN defined, scenario 2 → stall_cnt=4; undefined → stall_cnt=0 throughout.
- Non-HiLo instruction in ID during BUSY (ID_is* flags all 0) → ID_stall_o=0.

Source files
------------

// File: rtl/mdu_hazard_ctrl.sv
// mdu_hazard_ctrl
// Sequencing and stall controller for the multi-cycle multiply/divide unit of
// a 5-stage MIPS pipeline. It launches MULT/MULTU/DIV/DIVU from EX, counts the
// MDU latency, pulses the HI/LO write enable on completion, and stalls ID while
// a HI/LO consumer or a second MDU op would collide with an op in flight.
//
// Parameters:
//   MULT_LAT  cycles from MDU_start to HiLo_we for MULT/MULTU (2..15)
//   DIV_LAT   cycles from MDU_start to HiLo_we for DIV/DIVU   (2..15)
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   EX_isMDU/isDiv/isSigned  MDU instruction in EX and its flavour
//   EX_flush         EX instruction squashed this cycle
//   MDU_abort        exception commit, kills any op in flight
//   ID_isR_HiLo/ID_isW_HiLo/ID_isMDU  HI/LO users in ID
//   MDU_start, MDU_op  launch pulse and {isDiv, isSigned}
//   HiLo_we          one-cycle HI/LO write enable
//   MDU_busy         op in flight (registered)
//   ID_stall_o       freeze PC and IF/ID, bubble ID/EX
//   stall_cnt        stall-cycle counter
//
// Optional feature macro: MDU_STALL_CNT_EN
//   defined   -> stall_cnt counts cycles with ID_stall_o=1 (wrapping)
//   undefined -> stall_cnt is tied to zero
module mdu_hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_isMDU,
  input  logic        EX_isDiv,
  input  logic        EX_isSigned,
  input  logic        EX_flush,
  input  logic        MDU_abort,
  input  logic        ID_isR_HiLo,
  input  logic        ID_isW_HiLo,
  input  logic        ID_isMDU,
  output logic        MDU_start,
  output logic [1:0]  MDU_op,
  output logic        HiLo_we,
  output logic        MDU_busy,
  output logic        ID_stall_o,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Counter is loaded with LAT-1 so that DONE falls exactly LAT cycles after start.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       go;

  // Abort outranks a launch; a launch while BUSY cannot happen and is ignored.
  assign go = EX_isMDU && !EX_flush && !MDU_abort && (state_q != BUSY);

  assign MDU_start = go;
  assign MDU_op    = go ? {EX_isDiv, EX_isSigned} : 2'b00;
  assign HiLo_we   = (state_q == DONE) && !MDU_abort;
  assign MDU_busy  = busy_q;

  // No stall in DONE: the write-first HI/LO register hands the new value to EX.
  assign ID_stall_o = (ID_isR_HiLo || ID_isW_HiLo || ID_isMDU) &&
                      ((state_q == BUSY) || go);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = BUSY;
          cnt_d   = EX_isDiv ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (MDU_abort) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MDU_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running performance counter; aborts do not clear it.
  assign stall_cnt_d = ID_stall_o ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 32'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

  // Latencies must fit the 4-bit counter and leave at least one BUSY cycle.
  always @(posedge clk) begin
    if (MULT_LAT < 2 || MULT_LAT > 15) $error("mdu_hazard_ctrl: MULT_LAT=%0d out of range 2..15", MULT_LAT);
    if (DIV_LAT < 2 || DIV_LAT > 15)   $error("mdu_hazard_ctrl: DIV_LAT=%0d out of range 2..15", DIV_LAT);
  end

endmodule

// File: tb/tb_mdu_hazard_ctrl.sv
module tb_mdu_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_isMDU, EX_isDiv, EX_isSigned, EX_flush, MDU_abort;
  logic        ID_isR_HiLo, ID_isW_HiLo, ID_isMDU;
  logic        MDU_start, HiLo_we, MDU_busy, ID_stall_o;
  logic [1:0]  MDU_op;
  logic [31:0] stall_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mdu_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_isMDU(EX_isMDU), .EX_isDiv(EX_isDiv), .EX_isSigned(EX_isSigned),
    .EX_flush(EX_flush), .MDU_abort(MDU_abort),
    .ID_isR_HiLo(ID_isR_HiLo), .ID_isW_HiLo(ID_isW_HiLo), .ID_isMDU(ID_isMDU),
    .MDU_start(MDU_start), .MDU_op(MDU_op), .HiLo_we(HiLo_we),
    .MDU_busy(MDU_busy), .ID_stall_o(ID_stall_o), .stall_cnt(stall_cnt)
  );

  // Observed vector layout: {start, op[1:0], we, busy, stall}
  logic [5:0] obs, exp_v;
  assign obs = {MDU_start, MDU_op, HiLo_we, MDU_busy, ID_stall_o};

  task automatic clear_inputs();
    EX_isMDU = 0; EX_isDiv = 0; EX_isSigned = 0; EX_flush = 0; MDU_abort = 0;
    ID_isR_HiLo = 0; ID_isW_HiLo = 0; ID_isMDU = 0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    total_cnt++;
    if (obs !== 6'b0 || stall_cnt !== 32'h0)
      $display("FAIL reset outputs got=%b cnt=%0d exp=000000 cnt=0", obs, stall_cnt);
    else pass_cnt++;
    $display("reset: outputs=%b stall_cnt=%0d", obs, stall_cnt);
    rst_n = 1;
    next_cycle();
  endtask

  // MULT at k=0, MFHI held in ID from k=1 until it advances at the DONE cycle.
  task automatic test_mult_stall();
    logic [31:0] exp_sc;
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      clear_inputs();
      EX_isMDU = (k == 0); EX_isSigned = (k == 0);
      ID_isR_HiLo = (k >= 1 && k <= 5);
      @(negedge clk);
      exp_v = {(k == 0), (k == 0) ? 2'b01 : 2'b00, (k == 5), (k >= 1 && k <= 4), (k >= 1 && k <= 4)};
`ifdef MDU_STALL_CNT_EN
      exp_sc = (k <= 1) ? 32'd0 : ((k >= 5) ? 32'd4 : 32'(k - 1));
`else
      exp_sc = 32'd0;
`endif
      total_cnt++;
      if (obs !== exp_v || stall_cnt !== exp_sc)
        $display("FAIL mult_stall k=%0d got=%b cnt=%0d exp=%b cnt=%0d", k, obs, stall_cnt, exp_v, exp_sc);
      else pass_cnt++;
      $display("mult_stall k=%0d obs=%b stall_cnt=%0d", k, obs, stall_cnt);
      next_cycle();
    end
  endtask

  // DIVU at k=0, DIV waits in ID, launches back-to-back in the DONE cycle.
  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k <= 21; k++) begin
      clear_inputs();
      if (k == 0)  begin EX_isMDU = 1; EX_isDiv = 1; end
      if (k == 10) begin EX_isMDU = 1; EX_isDiv = 1; EX_isSigned = 1; end
      ID_isMDU = (k >= 1 && k <= 9);
      @(negedge clk);
      exp_v = {(k == 0 || k == 10),
               (k == 0) ? 2'b10 : ((k == 10) ? 2'b11 : 2'b00),
               (k == 10 || k == 20),
               ((k >= 1 && k <= 9) || (k >= 11 && k <= 19)),
               (k >= 1 && k <= 9)};
      total_cnt++;
      if (obs !== exp_v)
        $display("FAIL back_to_back k=%0d got=%b exp=%b", k, obs, exp_v);
      else pass_cnt++;
      $display("back_to_back k=%0d obs=%b", k, obs);
      next_cycle();
    end
  endtask

  // Flushed MULT must not launch; MFHI afterwards must not stall.
  task automatic test_flush();
    do_reset();
    for (int k = 0; k <= 2; k++) begin
      clear_inputs();
      EX_isMDU = (k == 0); EX_flush = (k == 0);
      ID_isR_HiLo = (k >= 1);
      @(negedge clk);
      exp_v = 6'b0;
      total_cnt++;
      if (obs !== exp_v)
        $display("FAIL flush k=%0d got=%b exp=%b", k, obs, exp_v);
      else pass_cnt++;
      $display("flush k=%0d obs=%b", k, obs);
      next_cycle();
    end
  endtask

  // DIV at k=0 aborted at k=4: idle from k=5, no write at k=10.
  task automatic test_abort_busy();
    do_reset();
    for (int k = 0; k <= 11; k++) begin
      clear_inputs();
      if (k == 0) begin EX_isMDU = 1; EX_isDiv = 1; EX_isSigned = 1; end
      MDU_abort = (k == 4);
      @(negedge clk);
      exp_v = {(k == 0), (k == 0) ? 2'b11 : 2'b00, 1'b0, (k >= 1 && k <= 4), 1'b0};
      total_cnt++;
      if (obs !== exp_v)
        $display("FAIL abort_busy k=%0d got=%b exp=%b", k, obs, exp_v);
      else pass_cnt++;
      $display("abort_busy k=%0d obs=%b", k, obs);
      next_cycle();
    end
  endtask

  // Abort in DONE suppresses the write and beats a simultaneous launch;
  // relaunch from IDLE at k=6 works.
  task automatic test_abort_done();
    do_reset();
    for (int k = 0; k <= 7; k++) begin
      clear_inputs();
      if (k == 0 || k == 5 || k == 6) begin EX_isMDU = 1; EX_isSigned = 1; end
      MDU_abort = (k == 5);
      @(negedge clk);
      exp_v = {(k == 0 || k == 6), (k == 0 || k == 6) ? 2'b01 : 2'b00, 1'b0,
               ((k >= 1 && k <= 4) || k == 7), 1'b0};
      total_cnt++;
      if (obs !== exp_v)
        $display("FAIL abort_done k=%0d got=%b exp=%b", k, obs, exp_v);
      else pass_cnt++;
      $display("abort_done k=%0d obs=%b", k, obs);
      next_cycle();
    end
  endtask

  // Stray MDU op while BUSY is ignored; non-HiLo ID instructions never stall;
  // MFHI arriving in DONE does not stall.
  task automatic test_busy_ignore();
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      clear_inputs();
      if (k == 0) begin EX_isMDU = 1; EX_isSigned = 1; end
      if (k == 2) begin EX_isMDU = 1; EX_isDiv = 1; end
      ID_isR_HiLo = (k == 5);
      @(negedge clk);
      exp_v = {(k == 0), (k == 0) ? 2'b01 : 2'b00, (k == 5), (k >= 1 && k <= 4), 1'b0};
      total_cnt++;
      if (obs !== exp_v)
        $display("FAIL busy_ignore k=%0d got=%b exp=%b", k, obs, exp_v);
      else pass_cnt++;
      $display("busy_ignore k=%0d obs=%b", k, obs);
      next_cycle();
    end
  endtask

  // Asynchronous reset in the middle of BUSY clears everything at once.
  task automatic test_reset_mid_busy();
    do_reset();
    EX_isMDU = 1; EX_isSigned = 1;
    next_cycle();
    clear_inputs(); ID_isR_HiLo = 1;
    next_cycle();
    #1;
    rst_n = 0;
    #1;
    total_cnt++;
    if ({HiLo_we, MDU_busy, ID_stall_o} !== 3'b000 || stall_cnt !== 32'h0)
      $display("FAIL reset_mid_busy async got we/busy/stall=%b cnt=%0d exp=000 cnt=0",
               {HiLo_we, MDU_busy, ID_stall_o}, stall_cnt);
    else pass_cnt++;
    $display("reset_mid_busy async obs=%b stall_cnt=%0d", obs, stall_cnt);
    next_cycle();
    rst_n = 1;
    clear_inputs();
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== 6'b0)
        $display("FAIL reset_mid_busy k=%0d got=%b exp=000000", k, obs);
      else pass_cnt++;
      $display("reset_mid_busy k=%0d obs=%b", k, obs);
      next_cycle();
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_mult_stall();
    test_back_to_back();
    test_flush();
    test_abort_busy();
    test_abort_done();
    test_busy_ignore();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
